// File: rtl/cgra_trace_capture_if.sv
// Frame stream from the trace capture stage to the CGRA lane monitor.
// master drives frames; slave returns out_ready.
interface cgra_trace_capture_if #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*(DW+1)-1:0] out_lanes;
    logic [CNT_W-1:0]        out_seq;

    modport master (
        output out_valid,
        output out_lanes,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_lanes,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/cgra_trace_capture.sv
// Trace capture: packs CGRA lane outputs into {valid,data} frames, buffers them in a
// fall-through FIFO and hands them to the lane monitor with sequence tags and drop accounting.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for cap_start; offers ignored
// ST_CAPTURE | offered frames pushed (or dropped when full), budget counted
// ST_DRAIN   | no new frames; waits for the FIFO to empty, then back to idle
module cgra_trace_capture #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cap_start,
    input  logic                  cap_stop,
    input  logic [CNT_W-1:0]      cfg_frames,
    input  logic [LANES-1:0]      lane_valid,
    input  logic [LANES*DW-1:0]   lane_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_cnt,
    cgra_trace_capture_if.master  out_if
);
    localparam int FW = LANES * (DW + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic [CNT_W-1:0] offered_q, offered_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    logic [FW-1:0]    mem_lanes_q [DEPTH];
    logic [CNT_W-1:0] mem_seq_q   [DEPTH];

    logic [FW-1:0]    frame;
    logic [CNT_W-1:0] offered_inc;
    logic             offer, pop, full, push, drop, budget_hit;

    always_comb begin
        frame = '0;
        for (int i = 0; i < LANES; i++) begin
            frame[i*(DW+1) +: DW+1] = {lane_valid[i], lane_data[i*DW +: DW]};
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
    assign offer       = (state_q == ST_CAPTURE) && (lane_valid != '0);
    assign pop         = (count_q != '0) && out_if.out_ready;
    assign full        = (count_q == FULL_CNT) && !pop;
    assign push        = offer && !full;
    assign drop        = offer && full;
    assign offered_inc = offered_q + 1'b1;
    assign budget_hit  = offer && (budget_q != '0) && (offered_inc == budget_q);

    always_comb begin
        state_d   = state_q;
        budget_d  = budget_q;
        offered_d = offered_q;
        seq_d     = seq_q;
        drop_d    = drop_q;

        if (offer) offered_d = offered_inc;
        if (push) seq_d = seq_q + 1'b1;
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cap_start) begin
                    state_d   = ST_CAPTURE;
                    budget_d  = cfg_frames;
                    offered_d = '0;
                    seq_d     = '0;
                    drop_d    = '0;
                end
            end
            ST_CAPTURE: begin
                if (cap_stop || budget_hit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (count_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            budget_q  <= '0;
            offered_q <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            budget_q  <= budget_d;
            offered_q <= offered_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is never reset; its contents are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_lanes_q[wr_ptr_q] <= frame;
            mem_seq_q[wr_ptr_q]   <= seq_q;
        end
    end

    assign out_if.out_valid = (count_q != '0);
    assign out_if.out_lanes = out_if.out_valid ? mem_lanes_q[rd_ptr_q] : '0;
    assign out_if.out_seq   = out_if.out_valid ? mem_seq_q[rd_ptr_q] : '0;
    assign busy             = (state_q != ST_IDLE);
    assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_cgra_trace_capture.sv
// Self-checking bench for cgra_trace_capture: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based reference model.
module tb_cgra_trace_capture;
    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int FW    = LANES * (DW + 1);
    localparam int VW    = 1 + CNT_W + FW + 1 + CNT_W;

    typedef struct {
        logic [FW-1:0]    lanes;
        logic [CNT_W-1:0] seq;
    } frame_t;

    logic                clock = 1'b0;
    logic                reset;
    logic                cap_start;
    logic                cap_stop;
    logic [CNT_W-1:0]    cfg_frames;
    logic [LANES-1:0]    lane_valid;
    logic [LANES*DW-1:0] lane_data;
    logic                busy;
    logic [CNT_W-1:0]    drop_cnt;

    cgra_trace_capture_if #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) oif ();

    cgra_trace_capture #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .cap_start  (cap_start),
        .cap_stop   (cap_stop),
        .cfg_frames (cfg_frames),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .out_if     (oif)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 capturing, 2 draining.
    frame_t           m_q[$];
    int               m_phase = 0;
    logic [CNT_W-1:0] m_seq = '0, m_drop = '0, m_offered = '0, m_budget = '0;

    logic [VW-1:0] dut_view;
    assign dut_view = {oif.out_valid, oif.out_seq, oif.out_lanes, busy, drop_cnt};

    function automatic logic [VW-1:0] model_view();
        logic             v = (m_q.size() > 0);
        logic [CNT_W-1:0] s = '0;
        logic [FW-1:0]    l = '0;
        logic             b = (m_phase != 0);
        if (v) begin
            s = m_q[0].seq;
            l = m_q[0].lanes;
        end
        return {v, s, l, b, m_drop};
    endfunction

    function automatic logic [LANES*DW-1:0] rand_data();
        logic [LANES*DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic model_step();
        frame_t f;
        int     pre;
        pre = m_q.size();
        if (reset) begin
            m_q.delete();
            m_phase = 0; m_seq = '0; m_drop = '0; m_offered = '0; m_budget = '0;
            return;
        end
        if (pre > 0 && oif.out_ready) f = m_q.pop_front();
        if (m_phase == 1 && lane_valid != '0) begin
            m_offered = m_offered + 1'b1;
            if (m_q.size() < DEPTH) begin
                for (int i = 0; i < LANES; i++)
                    f.lanes[i*(DW+1) +: DW+1] = {lane_valid[i], lane_data[i*DW +: DW]};
                f.seq = m_seq;
                m_q.push_back(f);
                m_seq = m_seq + 1'b1;
            end else if (m_drop != '1) begin
                m_drop = m_drop + 1'b1;
            end
        end
        if (m_phase == 0 && cap_start) begin
            m_phase = 1; m_budget = cfg_frames; m_seq = '0; m_drop = '0; m_offered = '0;
        end else if (m_phase == 1 && (cap_stop || (m_budget != '0 && m_offered == m_budget))) begin
            m_phase = 2;
        end else if (m_phase == 2 && pre == 0) begin
            m_phase = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cap_start = 1'b0; cap_stop = 1'b0; lane_valid = '0; oif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if (dut_view !== model_view()) begin
            miscompares++; $display("FAIL reset_view got=%h want=%h", dut_view, model_view());
        end
        vectors++;
        if ({oif.out_valid, busy, drop_cnt, oif.out_seq} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_const got v=%b busy=%b drop=%h seq=%h want 0,0,0,0",
                     oif.out_valid, busy, drop_cnt, oif.out_seq);
        end
    endtask

    task automatic test_basic();
        int popped = 0, last_pop = -1, fall = -1;
        cfg_frames = 3; cap_start = 1'b1; tick(); cap_start = 1'b0;
        oif.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 3) begin
                lane_valid = 16'h0001;
                lane_data  = rand_data();
                lane_data[31:0] = 32'(32'h11 * (c + 1));
            end else begin
                lane_valid = '0;
            end
            if (oif.out_valid) begin
                vectors++;
                if ({oif.out_seq, oif.out_lanes[32:0]} !== {16'(popped), 1'b1, 32'(32'h11 * (popped + 1))}) begin
                    miscompares++;
                    $display("FAIL basic_frame got seq=%h lane0=%h want seq=%h lane0=1%h",
                             oif.out_seq, oif.out_lanes[32:0], popped, 32'(32'h11 * (popped + 1)));
                end
                popped++; last_pop = c;
            end
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL basic_cycle got=%h want=%h", dut_view, model_view());
            end
            if (!busy && fall < 0) fall = c;
        end
        vectors++;
        if (popped != 3 || fall != last_pop + 1) begin
            miscompares++;
            $display("FAIL basic_count got pops=%0d busy_fall=%0d want pops=3 busy_fall=%0d",
                     popped, fall, last_pop + 1);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int n = 0;
        cfg_frames = 0; cap_start = 1'b1; tick(); cap_start = 1'b0;
        oif.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            lane_valid = 16'($urandom) | 16'h0001;
            lane_data  = rand_data();
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL bp_cycle got=%h want=%h", dut_view, model_view());
            end
            vectors++;
            if ({oif.out_valid, oif.out_seq} !== {1'b1, 16'h0}) begin
                miscompares++;
                $display("FAIL bp_head got v=%b seq=%h want v=1 seq=0", oif.out_valid, oif.out_seq);
            end
        end
        vectors++;
        if (drop_cnt !== 16'd2) begin
            miscompares++; $display("FAIL bp_drops got=%0d want=2", drop_cnt);
        end
        lane_valid = '0; cap_stop = 1'b1; tick(); cap_stop = 1'b0;
        oif.out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) begin
            if (oif.out_valid) begin
                vectors++;
                if (oif.out_seq !== 16'(n)) begin
                    miscompares++; $display("FAIL bp_seq got=%0d want=%0d", oif.out_seq, n);
                end
                n++;
            end
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL bp_drain got=%h want=%h", dut_view, model_view());
            end
        end
        vectors++;
        if (n != 8 || busy) begin
            miscompares++; $display("FAIL bp_total got frames=%0d busy=%b want frames=8 busy=0", n, busy);
        end
        idle_inputs();
    endtask

    task automatic test_full_pop();
        int n = 0;
        cfg_frames = 0; cap_start = 1'b1; tick(); cap_start = 1'b0;
        oif.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            lane_valid = 16'($urandom) | 16'h0100;
            lane_data  = rand_data();
            oif.out_ready = (k == 8);
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL full_cycle got=%h want=%h", dut_view, model_view());
            end
        end
        vectors++;
        if ({drop_cnt, oif.out_seq} !== {16'd0, 16'd1}) begin
            miscompares++;
            $display("FAIL full_pushpop got drop=%0d head=%0d want drop=0 head=1", drop_cnt, oif.out_seq);
        end
        oif.out_ready = 1'b0; lane_valid = 16'h0001; tick();
        vectors++;
        if (drop_cnt !== 16'd1) begin
            miscompares++; $display("FAIL full_still got drop=%0d want=1", drop_cnt);
        end
        lane_valid = '0; cap_stop = 1'b1; tick(); cap_stop = 1'b0;
        oif.out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) begin
            if (oif.out_valid) begin
                vectors++;
                if (oif.out_seq !== 16'(n + 1)) begin
                    miscompares++; $display("FAIL full_seq got=%0d want=%0d", oif.out_seq, n + 1);
                end
                n++;
            end
            tick();
        end
        vectors++;
        if (n != 8 || busy) begin
            miscompares++; $display("FAIL full_total got frames=%0d busy=%b want frames=8 busy=0", n, busy);
        end
        idle_inputs();
    endtask

    task automatic test_sparse();
        logic [LANES*DW-1:0] d;
        int n = 0;
        cfg_frames = 1; cap_start = 1'b1; tick(); cap_start = 1'b0;
        d = rand_data();
        d[15*DW +: DW] = 32'hDEADBEEF;
        d[31:0]        = 32'h5;
        lane_valid = 16'h8001; lane_data = d;
        tick();
        lane_valid = 16'($urandom) | 16'h0002; lane_data = rand_data();
        vectors++;
        if ({oif.out_lanes[15*33 +: 33], oif.out_lanes[32:0]} !== {33'h1_DEADBEEF, 33'h1_00000005}) begin
            miscompares++;
            $display("FAIL sparse_valid got l15=%h l0=%h want l15=1deadbeef l0=100000005",
                     oif.out_lanes[15*33 +: 33], oif.out_lanes[32:0]);
        end
        for (int i = 1; i < 15; i++) begin
            vectors++;
            if (oif.out_lanes[i*33 +: 33] !== {1'b0, d[i*DW +: DW]}) begin
                miscompares++;
                $display("FAIL sparse_lane%0d got=%h want=0%h", i, oif.out_lanes[i*33 +: 33], d[i*DW +: DW]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL sparse_cycle got=%h want=%h", dut_view, model_view());
            end
        end
        lane_valid = '0; oif.out_ready = 1'b1;
        for (int c = 0; c < 10 && busy; c++) begin
            if (oif.out_valid) n++;
            tick();
        end
        vectors++;
        if (n != 1 || busy || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL sparse_total got frames=%0d busy=%b drop=%0d want 1,0,0", n, busy, drop_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_early_stop();
        int n = 0;
        cfg_frames = 0; cap_start = 1'b1; tick(); cap_start = 1'b0;
        oif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lane_valid = 16'($urandom) | 16'h0010;
            lane_data  = rand_data();
            cap_stop   = (k == 4);
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL stop_cycle got=%h want=%h", dut_view, model_view());
            end
        end
        cap_stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lane_valid = 16'($urandom) | 16'h0004;
            lane_data  = rand_data();
            cfg_frames = 16'd2;
            cap_start  = (k == 1);
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL stop_drain got=%h want=%h", dut_view, model_view());
            end
        end
        cap_start = 1'b0;
        vectors++;
        if ({busy, drop_cnt} !== {1'b1, 16'd0}) begin
            miscompares++; $display("FAIL stop_ignored got busy=%b drop=%0d want busy=1 drop=0", busy, drop_cnt);
        end
        oif.out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) begin
            if (oif.out_valid) begin
                vectors++;
                if (oif.out_seq !== 16'(n)) begin
                    miscompares++; $display("FAIL stop_seq got=%0d want=%0d", oif.out_seq, n);
                end
                n++;
            end
            tick();
        end
        vectors++;
        if (n != 5 || busy || oif.out_valid) begin
            miscompares++;
            $display("FAIL stop_total got frames=%0d busy=%b valid=%b want 5,0,0", n, busy, oif.out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        cfg_frames = 0; cap_start = 1'b1; tick(); cap_start = 1'b0;
        oif.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lane_valid = 16'($urandom) | 16'h0001; lane_data = rand_data(); tick();
        end
        oif.out_ready = 1'b1;
        lane_valid = 16'hFFFF; lane_data = rand_data(); tick();
        oif.out_ready = 1'b0;
        lane_valid = 16'hFFFF; reset = 1'b1; tick(); reset = 1'b0;
        lane_valid = '0;
        vectors++;
        if ({oif.out_valid, busy, drop_cnt} !== {1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL rstmid_state got v=%b busy=%b drop=%0d want 0,0,0", oif.out_valid, busy, drop_cnt);
        end
        cfg_frames = 0; cap_start = 1'b1; tick(); cap_start = 1'b0;
        lane_valid = 16'h0040; lane_data = rand_data(); tick(); lane_valid = '0;
        vectors++;
        if ({oif.out_valid, oif.out_seq} !== {1'b1, 16'd0}) begin
            miscompares++;
            $display("FAIL rstmid_restart got v=%b seq=%0d want v=1 seq=0", oif.out_valid, oif.out_seq);
        end
        vectors++;
        if (dut_view !== model_view()) begin
            miscompares++; $display("FAIL rstmid_view got=%h want=%h", dut_view, model_view());
        end
        cap_stop = 1'b1; tick(); cap_stop = 1'b0;
        oif.out_ready = 1'b1;
        for (int c = 0; c < 10 && busy; c++) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_drain got busy=%b want=0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int bias;
        for (int c = 0; c < 600; c++) begin
            bias = ((c / 100) % 2 == 0) ? 20 : 90;
            cap_start     = ($urandom_range(0, 15) == 0);
            cap_stop      = ($urandom_range(0, 31) == 0);
            cfg_frames    = 16'($urandom_range(0, 12));
            lane_valid    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            lane_data     = rand_data();
            oif.out_ready = ($urandom_range(0, 99) < bias);
            reset         = ($urandom_range(0, 249) == 0);
            tick();
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++; $display("FAIL random_c%0d got=%h want=%h", c, dut_view, model_view());
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1; cfg_frames = '0; lane_data = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_sparse();
        test_early_stop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
